ps2_key_ctrl: RTL and testbench

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

---
 rtl/ps2_key_ctrl.sv | 134 +++++++++++++
 tb/tb_ps2_key_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code consumer: pops bytes from the keyboard receiver FIFO, tracks
// E0/F0 prefixes, and reports make/break events, the held key and a press count.
module ps2_key_ctrl #(
    parameter int unsigned COUNT_W       = 8,
    parameter bit          REPEAT_FILTER = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         fifo_data,
    input  logic               fifo_ready,
    input  logic               fifo_overflow,
    output logic               nextdata_n,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_valid,
    output logic               make_pulse,
    output logic               break_pulse,
    output logic [COUNT_W-1:0] press_count,
    output logic               err_sticky
);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {IDLE, POP, PROC} state_t;

    state_t             state, state_nx;
    logic [7:0]         byte_q, byte_nx;
    logic               ext_pend, ext_nx;
    logic               brk_pend, brk_nx;
    logic [7:0]         code_nx;
    logic               kext_nx;
    logic               valid_nx;
    logic               make_nx;
    logic               brk_pulse_nx;
    logic [COUNT_W-1:0] count_nx;
    logic               err_nx;
    logic               match;

    // Reset suppresses the pop strobe in the same cycle so a latched byte stays queued.
    assign nextdata_n = !((state == POP) && !rst);

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            byte_q      <= 8'h00;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_valid   <= 1'b0;
            make_pulse  <= 1'b0;
            break_pulse <= 1'b0;
            press_count <= '0;
            err_sticky  <= 1'b0;
        end else begin
            state       <= state_nx;
            byte_q      <= byte_nx;
            ext_pend    <= ext_nx;
            brk_pend    <= brk_nx;
            key_code    <= code_nx;
            key_ext     <= kext_nx;
            key_valid   <= valid_nx;
            make_pulse  <= make_nx;
            break_pulse <= brk_pulse_nx;
            press_count <= count_nx;
            err_sticky  <= err_nx;
        end
    end

    // Next-state and decode
    always_comb begin
        state_nx     = state;
        byte_nx      = byte_q;
        ext_nx       = ext_pend;
        brk_nx       = brk_pend;
        code_nx      = key_code;
        kext_nx      = key_ext;
        valid_nx     = key_valid;
        make_nx      = 1'b0;
        brk_pulse_nx = 1'b0;
        count_nx     = press_count;
        err_nx       = err_sticky;
        match        = 1'b0;

        // Overflow drops any half-received prefix before the byte is decoded.
        if (fifo_overflow) begin
            err_nx = 1'b1;
            ext_nx = 1'b0;
            brk_nx = 1'b0;
        end

        case (state)
            IDLE: begin
                if (fifo_ready) begin
                    byte_nx  = fifo_data;
                    state_nx = POP;
                end
            end
            POP: begin
                state_nx = PROC;
            end
            PROC: begin
                state_nx = IDLE;
                if (byte_q == CODE_EXT) begin
                    ext_nx = 1'b1;
                end else if (byte_q == CODE_BRK) begin
                    brk_nx = 1'b1;
                end else begin
                    match = (byte_q == key_code) && (ext_nx == key_ext);
                    if (brk_nx) begin
                        brk_pulse_nx = 1'b1;
                        if (match) begin
                            valid_nx = 1'b0;
                        end
                    end else if (!(REPEAT_FILTER && key_valid && match)) begin
                        code_nx  = byte_q;
                        kext_nx  = ext_nx;
                        valid_nx = 1'b1;
                        make_nx  = 1'b1;
                        count_nx = press_count + COUNT_W'(1);
                    end
                    ext_nx = 1'b0;
                    brk_nx = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: two instances (repeat filter on/off) share one modelled
// receiver FIFO and are checked against a byte-level event model.
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_ready = 1'b0;
    logic       fifo_overflow = 1'b0;

    logic       d_nd[2];
    logic [7:0] d_code[2];
    logic       d_ext[2];
    logic       d_valid[2];
    logic       d_make[2];
    logic       d_brk[2];
    logic [7:0] d_count[2];
    logic       d_err[2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ps2_key_ctrl #(.COUNT_W(8), .REPEAT_FILTER(1'b1)) dut_f (
        .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_ready(fifo_ready),
        .fifo_overflow(fifo_overflow), .nextdata_n(d_nd[0]), .key_code(d_code[0]),
        .key_ext(d_ext[0]), .key_valid(d_valid[0]), .make_pulse(d_make[0]),
        .break_pulse(d_brk[0]), .press_count(d_count[0]), .err_sticky(d_err[0])
    );

    ps2_key_ctrl #(.COUNT_W(8), .REPEAT_FILTER(1'b0)) dut_n (
        .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_ready(fifo_ready),
        .fifo_overflow(fifo_overflow), .nextdata_n(d_nd[1]), .key_code(d_code[1]),
        .key_ext(d_ext[1]), .key_valid(d_valid[1]), .make_pulse(d_make[1]),
        .break_pulse(d_brk[1]), .press_count(d_count[1]), .err_sticky(d_err[1])
    );

    // Receiver FIFO contents and reference model state (index 0: filter on, 1: off)
    logic [7:0] q[$];
    bit         filt[2] = '{1'b1, 1'b0};
    logic [7:0] m_code[2];
    bit         m_ext[2], m_valid[2], m_make[2], m_brk[2], m_err[2], m_extp[2], m_brkp[2];
    logic [7:0] m_count[2];
    bit         pend_valid = 1'b0;
    logic [7:0] pend_byte = 8'h00;

    int make_cnt[2], brk_cnt[2];
    bit last_make[2];
    int pulse_err = 0, proto_err = 0, pops = 0, cycle = 0, last_pop = -10;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_code[k] = 8'h00; m_ext[k] = 1'b0; m_valid[k] = 1'b0; m_count[k] = 8'h00;
            m_err[k] = 1'b0; m_extp[k] = 1'b0; m_brkp[k] = 1'b0;
        end
    endfunction

    function automatic void decode(input int k, input logic [7:0] b);
        bit hit;
        if (b == 8'hE0) m_extp[k] = 1'b1;
        else if (b == 8'hF0) m_brkp[k] = 1'b1;
        else begin
            hit = (b == m_code[k]) && (m_extp[k] == m_ext[k]);
            if (m_brkp[k]) begin
                m_brk[k] = 1'b1;
                if (hit) m_valid[k] = 1'b0;
            end else if (!(filt[k] && m_valid[k] && hit)) begin
                m_code[k] = b; m_ext[k] = m_extp[k]; m_valid[k] = 1'b1;
                m_make[k] = 1'b1; m_count[k] = m_count[k] + 8'd1;
            end
            m_extp[k] = 1'b0; m_brkp[k] = 1'b0;
        end
    endfunction

    task automatic drive_fifo();
        fifo_ready = (q.size() != 0);
        fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        drive_fifo();
    endtask

    // One clock: observe at negedge, advance the model for the coming edge, service the FIFO.
    task automatic tick();
        bit pop_now;
        @(negedge clk);
        cycle++;
        for (int k = 0; k < 2; k++) begin
            if (d_make[k] !== m_make[k] || d_brk[k] !== m_brk[k]) pulse_err++;
            if (d_make[k] === 1'b1 && d_brk[k] === 1'b1) pulse_err++;
            if (d_make[k] === 1'b1) make_cnt[k]++;
            if (d_brk[k] === 1'b1) brk_cnt[k]++;
            last_make[k] = (d_make[k] === 1'b1);
            m_make[k] = 1'b0;
            m_brk[k]  = 1'b0;
        end
        pop_now = (d_nd[0] === 1'b0);
        if (d_nd[1] !== d_nd[0]) proto_err++;
        if (pop_now) begin
            pops++;
            if (cycle - last_pop < 3) proto_err++;
            last_pop = cycle;
        end
        if (rst) begin
            model_reset();
            pend_valid = 1'b0;
        end else begin
            if (fifo_overflow) begin
                for (int k = 0; k < 2; k++) begin
                    m_err[k] = 1'b1; m_extp[k] = 1'b0; m_brkp[k] = 1'b0;
                end
            end
            if (pend_valid) begin
                for (int k = 0; k < 2; k++) decode(k, pend_byte);
                pend_valid = 1'b0;
            end
            if (pop_now) begin
                pend_valid = 1'b1;
                pend_byte  = fifo_data;
            end
        end
        @(posedge clk);
        if (pop_now && q.size() != 0) q.delete(0);
        #1;
        drive_fifo();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (4) tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout bytes_left=%0d expected=0", q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_overflow = 1'b0;
        q.delete();
        drive_fifo();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            make_cnt[k] = 0;
            brk_cnt[k]  = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({d_code[k], d_ext[k], d_valid[k], d_count[k], d_err[k], d_make[k], d_brk[k], d_nd[k]}
                !== {8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL reset_values[%0d] got=%h_%b%b_%h_%b%b%b%b expected=00_00_00_0001", k,
                         d_code[k], d_ext[k], d_valid[k], d_count[k], d_err[k], d_make[k], d_brk[k], d_nd[k]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_make_break();
        int lat = -1;
        logic [7:0] code_at = 8'h00, cnt_at = 8'h00;
        logic ext_at = 1'b1;
        do_reset();
        push(8'h1C);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (last_make[0] && lat < 0) begin
                lat = i;
                code_at = d_code[0]; ext_at = d_ext[0]; cnt_at = d_count[0];
            end
        end
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL make_latency got=%0d expected=3", lat);
        end
        checks++;
        if ({code_at, ext_at, cnt_at} !== {8'h1C, 1'b0, 8'h01}) begin
            failures++;
            $display("FAIL make_outputs got=%h/%b/%h expected=1c/0/01", code_at, ext_at, cnt_at);
        end
        push(8'hF0); push(8'h1C);
        drain(40);
        checks++;
        if (brk_cnt[0] != 1 || d_valid[0] !== 1'b0 || d_code[0] !== 8'h1C || d_count[0] !== 8'h01) begin
            failures++;
            $display("FAIL break_1c got=brk%0d/v%b/%h/%h expected=brk1/v0/1c/01",
                     brk_cnt[0], d_valid[0], d_code[0], d_count[0]);
        end
    endtask

    task automatic test_extended();
        int p0;
        do_reset();
        p0 = pops;
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        drain(60);
        checks++;
        if (pops - p0 != 5) begin
            failures++;
            $display("FAIL ext_pops got=%0d expected=5", pops - p0);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({d_code[k], d_ext[k], d_valid[k], d_count[k]} !== {8'h75, 1'b1, 1'b0, 8'h01}
                || make_cnt[k] != 1 || brk_cnt[k] != 1) begin
                failures++;
                $display("FAIL ext_key[%0d] got=%h/%b/%b/%h mk%0d bk%0d expected=75/1/0/01 mk1 bk1", k,
                         d_code[k], d_ext[k], d_valid[k], d_count[k], make_cnt[k], brk_cnt[k]);
            end
        end
    endtask

    task automatic test_repeat();
        do_reset();
        repeat (3) push(8'h1C);
        drain(40);
        checks++;
        if (d_count[0] !== 8'd1 || make_cnt[0] != 1) begin
            failures++;
            $display("FAIL repeat_filtered got=cnt%0d mk%0d expected=cnt1 mk1", d_count[0], make_cnt[0]);
        end
        checks++;
        if (d_count[1] !== 8'd3 || make_cnt[1] != 3) begin
            failures++;
            $display("FAIL repeat_unfiltered got=cnt%0d mk%0d expected=cnt3 mk3", d_count[1], make_cnt[1]);
        end
    endtask

    task automatic test_wrap();
        int pe0;
        do_reset();
        pe0 = pulse_err;
        for (int b = 0; b < 256; b++) begin
            if (b != 'hE0 && b != 'hF0) begin
                push(8'(b)); push(8'hF0); push(8'(b));
            end
        end
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        push(8'hE0); push(8'h6B); push(8'hE0); push(8'hF0); push(8'h6B);
        drain(4000);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (d_count[k] !== 8'h00 || d_err[k] !== 1'b0 || make_cnt[k] != 256) begin
                failures++;
                $display("FAIL wrap[%0d] got=cnt%h err%b mk%0d expected=cnt00 err0 mk256", k,
                         d_count[k], d_err[k], make_cnt[k]);
            end
        end
        checks++;
        if (pulse_err != pe0) begin
            failures++;
            $display("FAIL wrap_pulses got=%0d expected=%0d", pulse_err, pe0);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        push(8'hF0);
        drain(20);
        fifo_overflow = 1'b1;
        tick();
        fifo_overflow = 1'b0;
        push(8'h1C);
        drain(20);
        checks++;
        if ({d_err[0], d_count[0], d_code[0], d_valid[0]} !== {1'b1, 8'h01, 8'h1C, 1'b1}
            || make_cnt[0] != 1 || brk_cnt[0] != 0) begin
            failures++;
            $display("FAIL overflow got=err%b cnt%h %h v%b mk%0d bk%0d expected=err1 cnt01 1c v1 mk1 bk0",
                     d_err[0], d_count[0], d_code[0], d_valid[0], make_cnt[0], brk_cnt[0]);
        end
    endtask

    task automatic test_reset_in_pop();
        int p0;
        do_reset();
        p0 = pops;
        push(8'h5A);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (q.size() != 1 || pops != p0) begin
            failures++;
            $display("FAIL rst_pop_kept got=q%0d pops%0d expected=q1 pops0", q.size(), pops - p0);
        end
        checks++;
        if ({d_code[0], d_valid[0], d_count[0], d_make[0], d_nd[0]} !== {8'h00, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL rst_pop_outputs got=%h v%b %h mk%b nd%b expected=00 v0 00 mk0 nd1",
                     d_code[0], d_valid[0], d_count[0], d_make[0], d_nd[0]);
        end
        drain(20);
        checks++;
        if (d_code[0] !== 8'h5A || d_count[0] !== 8'h01) begin
            failures++;
            $display("FAIL rst_pop_replay got=%h/%h expected=5a/01", d_code[0], d_count[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool[8] = '{8'hE0, 8'hF0, 8'h1C, 8'h1C, 8'h75, 8'h32, 8'h5A, 8'h00};
        logic [7:0] b;
        int pe0, pr0, bad;
        do_reset();
        pe0 = pulse_err; pr0 = proto_err; bad = 0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0 && q.size() < 4) begin
                b = pool[$urandom_range(0, 7)];
                if (b == 8'h00) b = 8'($urandom);
                push(b);
            end
            fifo_overflow = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({d_code[k], d_ext[k], d_valid[k], d_count[k], d_err[k]}
                    !== {m_code[k], m_ext[k], m_valid[k], m_count[k], m_err[k]}) begin
                    failures++;
                    bad++;
                    if (bad < 10)
                        $display("FAIL random_state[%0d] cyc=%0d got=%h/%b/%b/%h/%b expected=%h/%b/%b/%h/%b",
                                 k, cycle, d_code[k], d_ext[k], d_valid[k], d_count[k], d_err[k],
                                 m_code[k], m_ext[k], m_valid[k], m_count[k], m_err[k]);
                end
            end
        end
        rst = 1'b0;
        fifo_overflow = 1'b0;
        drain(200);
        checks++;
        if (pulse_err != pe0) begin
            failures++;
            $display("FAIL random_pulses got=%0d expected=%0d", pulse_err, pe0);
        end
        checks++;
        if (proto_err != pr0) begin
            failures++;
            $display("FAIL pop_protocol got=%0d expected=%0d", proto_err, pr0);
        end
    endtask

    initial begin
        model_reset();
        for (int k = 0; k < 2; k++) begin
            m_make[k] = 1'b0; m_brk[k] = 1'b0; make_cnt[k] = 0; brk_cnt[k] = 0; last_make[k] = 1'b0;
        end
        #1;
        test_reset();
        test_make_break();
        test_extended();
        test_repeat();
        test_wrap();
        test_overflow();
        test_reset_in_pop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time_limit reached expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
